// File: rtl/neb_sum_accum.sv
// ---------------------------------------------------------------------------
// neb_sum_accum
//
// Purpose:
//   Windowed statistics stage that sits after the 8-bit operand-sum adder.
//   It collects 2^WIN_LOG2 samples over a valid/ready input handshake and then
//   presents the window total, the truncated average and the window maximum
//   on a valid/ready output handshake. The result is held stable until the
//   consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ena        global enable; when low, no sample is taken and no state moves
//              (clear, reset and a pending output handshake still act)
//   clear      synchronous abort of the current window / pending result
//   in_data    sample value (DATA_W bits, unsigned)
//   in_valid   sample present
//   in_ready   block can take a sample this cycle
//   out_sum    total of the completed window (ACC_W bits)
//   out_avg    out_sum >> WIN_LOG2, truncated
//   out_max    largest sample of the completed window
//   out_valid  result available
//   out_ready  consumer accepts the result
//   busy       a window is partly filled or a result is being held
// ---------------------------------------------------------------------------
module neb_sum_accum #(
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 2,
    parameter int ACC_W    = DATA_W + WIN_LOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_avg,
    output logic [DATA_W-1:0] out_max,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Counter value of the final sample in a window (all ones).
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    state_t              state;
    state_t              state_next;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [DATA_W-1:0]   max_val;
    logic [DATA_W-1:0]   max_next;
    logic [WIN_LOG2-1:0] cnt;
    logic [WIN_LOG2-1:0] cnt_next;

    logic [ACC_W-1:0]    out_sum_next;
    logic [DATA_W-1:0]   out_avg_next;
    logic [DATA_W-1:0]   out_max_next;
    logic                out_valid_next;

    logic                accept;
    logic [ACC_W-1:0]    acc_sum;
    logic [DATA_W-1:0]   max_cand;

    // The input side is open only while collecting, enabled and not being
    // cleared. rst_n is folded in so the handshake stays closed during reset.
    assign in_ready = rst_n && (state == ACCUM) && ena && !clear;
    assign accept   = in_valid && in_ready;
    assign busy     = (cnt != '0) || (state == HOLD);

    // Running totals including the sample offered this cycle. The first
    // sample of a window replaces the maximum outright so that nothing from
    // the previous window can leak into the new one.
    assign acc_sum  = acc + ACC_W'(in_data);
    assign max_cand = ((cnt == '0) || (in_data > max_val)) ? in_data : max_val;

    // Next-state and datapath decisions. Clear outranks everything below
    // reset and does not touch the presented result data. The HOLD handshake
    // is deliberately independent of ena so a consumer can always drain the
    // result, while sample acceptance already carries ena through in_ready.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        max_next       = max_val;
        cnt_next       = cnt;
        out_sum_next   = out_sum;
        out_avg_next   = out_avg;
        out_max_next   = out_max;
        out_valid_next = out_valid;

        if (clear) begin
            state_next     = ACCUM;
            acc_next       = '0;
            max_next       = '0;
            cnt_next       = '0;
            out_valid_next = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == CNT_LAST) begin
                            out_sum_next   = acc_sum;
                            out_avg_next   = DATA_W'(acc_sum >> WIN_LOG2);
                            out_max_next   = max_cand;
                            out_valid_next = 1'b1;
                            state_next     = HOLD;
                            acc_next       = '0;
                            max_next       = '0;
                            cnt_next       = '0;
                        end else begin
                            acc_next = acc_sum;
                            max_next = max_cand;
                            cnt_next = cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid_next = 1'b0;
                        state_next     = ACCUM;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

    // State, accumulator and result registers. Reset returns everything,
    // including the presented result, to zero without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            max_val   <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_max   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            max_val   <= max_next;
            cnt       <= cnt_next;
            out_sum   <= out_sum_next;
            out_avg   <= out_avg_next;
            out_max   <= out_max_next;
            out_valid <= out_valid_next;
        end
    end

endmodule

// File: tb/tb_neb_sum_accum.sv
// ---------------------------------------------------------------------------
// tb_neb_sum_accum
//
// Purpose:
//   Self-checking bench for neb_sum_accum with the default window of four
//   8-bit samples. A table of directed vectors, a few hand-written
//   multi-cycle sequences and a randomized run are all compared every cycle
//   against a window model built from a queue of accepted samples.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_neb_sum_accum;

    localparam int DATA_W   = 8;
    localparam int WIN_LOG2 = 2;
    localparam int ACC_W    = DATA_W + WIN_LOG2;
    localparam int WIN_LEN  = 1 << WIN_LOG2;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              clear;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_avg;
    logic [DATA_W-1:0] out_max;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    neb_sum_accum #(
        .DATA_W  (DATA_W),
        .WIN_LOG2(WIN_LOG2),
        .ACC_W   (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_sum  (out_sum),
        .out_avg  (out_avg),
        .out_max  (out_max),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: the samples accepted so far in the current window and
    // the result currently on offer.
    int win_q[$];
    bit m_valid;
    int m_sum;
    int m_avg;
    int m_max;

    // in_ready as seen just before the last edge, for the table comparisons.
    int seen_rdy;

    typedef struct {
        bit ena;
        bit clr;
        bit vld;
        int data;
        bit ordy;
        bit exp_rdy;
        bit exp_ov;
        bit exp_busy;
        int exp_sum;
        int exp_avg;
        int exp_max;
    } vec_t;

    vec_t vecs[15];

    // Single comparison with failure reporting.
    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model reset: empty window, no result, result registers zeroed.
    function automatic void modelReset();
        win_q.delete();
        m_valid = 1'b0;
        m_sum   = 0;
        m_avg   = 0;
        m_max   = 0;
    endfunction

    // Model of one clock edge given the inputs present before it.
    function automatic void modelStep(input bit e, input bit c, input bit v,
                                      input int d, input bit r);
        int s;
        int mx;
        if (c) begin
            win_q.delete();
            m_valid = 1'b0;
        end else if (m_valid) begin
            if (r) m_valid = 1'b0;
        end else if (e && v) begin
            win_q.push_back(d);
            if (win_q.size() == WIN_LEN) begin
                s  = 0;
                mx = 0;
                foreach (win_q[i]) begin
                    s += win_q[i];
                    if (win_q[i] > mx) mx = win_q[i];
                end
                m_sum   = s;
                m_avg   = s / WIN_LEN;
                m_max   = mx;
                m_valid = 1'b1;
                win_q.delete();
            end
        end
    endfunction

    // Compare every registered output against the model.
    task automatic checkModel();
        checkOutput("out_valid", int'(out_valid), int'(m_valid));
        checkOutput("busy", int'(busy), int'((win_q.size() != 0) || m_valid));
        checkOutput("out_sum", int'(out_sum), m_sum);
        checkOutput("out_avg", int'(out_avg), m_avg);
        checkOutput("out_max", int'(out_max), m_max);
    endtask

    // One clock cycle: drive inputs, check in_ready before the edge, step the
    // model at the edge, check outputs just after it. Entered and left 1 ns
    // after a rising edge.
    task automatic applyStimulus(input bit e, input bit c, input bit v,
                                 input int d, input bit r);
        ena       = e;
        clear     = c;
        in_valid  = v;
        in_data   = d[DATA_W-1:0];
        out_ready = r;
        #1;
        seen_rdy = int'(in_ready);
        checkOutput("in_ready", seen_rdy, int'(!m_valid && e && !c));
        @(posedge clk);
        modelStep(e, c, v, d, r);
        #1;
        checkModel();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        seen_rdy  = 0;
        rst_n     = 1'b0;
        ena       = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        modelReset();

        // Directed table: basic window, saturation bound, per-window max.
        vecs[0]  = '{1, 0, 1,  10, 1, 1, 0, 1,    0,   0,   0};
        vecs[1]  = '{1, 0, 1,  20, 1, 1, 0, 1,    0,   0,   0};
        vecs[2]  = '{1, 0, 1,  30, 1, 1, 0, 1,    0,   0,   0};
        vecs[3]  = '{1, 0, 1,  40, 1, 1, 1, 1,  100,  25,  40};
        vecs[4]  = '{1, 0, 0,   0, 1, 0, 0, 0,  100,  25,  40};
        vecs[5]  = '{1, 0, 1, 255, 1, 1, 0, 1,  100,  25,  40};
        vecs[6]  = '{1, 0, 1, 255, 1, 1, 0, 1,  100,  25,  40};
        vecs[7]  = '{1, 0, 1, 255, 1, 1, 0, 1,  100,  25,  40};
        vecs[8]  = '{1, 0, 1, 255, 1, 1, 1, 1, 1020, 255, 255};
        vecs[9]  = '{1, 0, 1,   0, 1, 0, 0, 0, 1020, 255, 255};
        vecs[10] = '{1, 0, 1,   0, 1, 1, 0, 1, 1020, 255, 255};
        vecs[11] = '{1, 0, 1,   0, 1, 1, 0, 1, 1020, 255, 255};
        vecs[12] = '{1, 0, 1,   0, 1, 1, 0, 1, 1020, 255, 255};
        vecs[13] = '{1, 0, 1,   3, 1, 1, 1, 1,    3,   0,   3};
        vecs[14] = '{1, 0, 0,   0, 1, 0, 0, 0,    3,   0,   3};

        // Reset state, checked while reset is still asserted.
        #1;
        checkOutput("rst in_ready", int'(in_ready), 0);
        checkOutput("rst out_valid", int'(out_valid), 0);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst out_sum", int'(out_sum), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ena, vecs[i].clr, vecs[i].vld, vecs[i].data, vecs[i].ordy);
            checkOutput($sformatf("tbl%0d in_ready", i), seen_rdy, int'(vecs[i].exp_rdy));
            checkOutput($sformatf("tbl%0d out_valid", i), int'(out_valid), int'(vecs[i].exp_ov));
            checkOutput($sformatf("tbl%0d busy", i), int'(busy), int'(vecs[i].exp_busy));
            checkOutput($sformatf("tbl%0d out_sum", i), int'(out_sum), vecs[i].exp_sum);
            checkOutput($sformatf("tbl%0d out_avg", i), int'(out_avg), vecs[i].exp_avg);
            checkOutput($sformatf("tbl%0d out_max", i), int'(out_max), vecs[i].exp_max);
        end

        // Enable gating in mid-window: stalled cycles accept nothing.
        $display("[TB] ena gating");
        applyStimulus(1, 0, 1, 7, 1);
        applyStimulus(1, 0, 1, 8, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 99, 1);
            checkOutput("ena0 in_ready", seen_rdy, 0);
            checkOutput("ena0 busy", int'(busy), 1);
        end
        applyStimulus(1, 0, 1, 9, 1);
        checkOutput("ena resume out_valid", int'(out_valid), 0);
        applyStimulus(1, 0, 1, 10, 1);
        checkOutput("ena out_valid", int'(out_valid), 1);
        checkOutput("ena out_sum", int'(out_sum), 34);
        checkOutput("ena out_max", int'(out_max), 10);
        applyStimulus(1, 0, 0, 0, 1);

        // Backpressure: result held across six stalled cycles.
        $display("[TB] backpressure");
        for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 1, i, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, 99, 0);
            checkOutput("bp in_ready", seen_rdy, 0);
            checkOutput("bp out_sum", int'(out_sum), 10);
            checkOutput("bp out_valid", int'(out_valid), 1);
        end
        applyStimulus(1, 0, 1, 99, 1);
        checkOutput("bp handshake in_ready", seen_rdy, 0);
        checkOutput("bp handshake out_valid", int'(out_valid), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 99, 0);
        checkOutput("bp next out_valid", int'(out_valid), 1);
        checkOutput("bp next out_sum", int'(out_sum), 396);
        checkOutput("bp next out_avg", int'(out_avg), 99);
        applyStimulus(1, 0, 0, 0, 1);

        // Clear mid-window, then clear coinciding with the last sample.
        $display("[TB] clear");
        applyStimulus(1, 0, 1, 50, 1);
        applyStimulus(1, 0, 1, 60, 1);
        applyStimulus(1, 1, 1, 70, 1);
        checkOutput("clr busy", int'(busy), 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 1, i, 0);
        checkOutput("clr out_sum", int'(out_sum), 10);
        checkOutput("clr out_max", int'(out_max), 4);
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 1);
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("clr last out_valid", int'(out_valid), 0);
        checkOutput("clr last busy", int'(busy), 0);
        checkOutput("clr last out_sum", int'(out_sum), 10);

        // Randomized traffic against the model.
        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
        end
        applyStimulus(1, 1, 0, 0, 0);

        // Asynchronous reset while holding a result.
        $display("[TB] async reset");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 77, 0);
        checkOutput("ar pre out_valid", int'(out_valid), 1);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        modelReset();
        checkOutput("ar out_valid", int'(out_valid), 0);
        checkOutput("ar busy", int'(busy), 0);
        checkOutput("ar out_sum", int'(out_sum), 0);
        checkOutput("ar out_avg", int'(out_avg), 0);
        checkOutput("ar out_max", int'(out_max), 0);
        checkOutput("ar in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 5, 1);
        checkOutput("ar window out_sum", int'(out_sum), 20);
        checkOutput("ar window out_valid", int'(out_valid), 1);
        applyStimulus(1, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
